lap_recorder: RTL and testbench

Lap/split capture stage that sits directly downstream of the stopwatch. It consumes the stopwatch's live BCD mm:ss digits and, on a lap request, stores a snapshot of the current time into a small on-chip buffer. It also computes the split (time elapsed since the previous lap) in BCD. Stored laps are read back through an indexed read port for the display path.

---
 rtl/lap_pkg.sv | 25 ++
 rtl/lap_recorder_if.sv | 31 +++
 rtl/bcd_time_sub.sv | 36 +++
 rtl/lap_recorder.sv | 142 ++++++++++++++
 tb/tb_lap_recorder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lap_pkg.sv
// Shared types and constants for the lap/split capture stage: BCD digit, mm:ss time
// struct, capture FSM states and digit limits.
package lap_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tenmin;
        bcd_t onemin;
        bcd_t tensec;
        bcd_t onesec;
    } time_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        CALC,
        ACK
    } state_t;

    localparam bcd_t       TENS_MAX      = 4'd5;
    localparam bcd_t       ONES_MAX      = 4'd9;
    localparam logic [1:0] SEL_STOPWATCH = 2'b01;

endpackage

// File: rtl/lap_recorder_if.sv
// Bundle between the stopwatch/display side and the lap recorder: live time and lap
// handshake in, indexed read port and buffer status out.
interface lap_recorder_if #(
    parameter int IDX_W = 3
);
    import lap_pkg::*;

    logic [1:0]     sel;
    bcd_t           tenmin, onemin, tensec, onesec;
    logic           lap_req;
    logic           lap_ack;
    logic           clr;
    logic [IDX_W-1:0] rd_idx;
    bcd_t           rd_tenmin, rd_onemin, rd_tensec, rd_onesec;
    bcd_t           sp_tenmin, sp_onemin, sp_tensec, sp_onesec;
    logic [IDX_W:0] count;
    logic           full, empty, ovf;

    modport master (
        output sel, tenmin, onemin, tensec, onesec, lap_req, clr, rd_idx,
        input  lap_ack, rd_tenmin, rd_onemin, rd_tensec, rd_onesec,
               sp_tenmin, sp_onemin, sp_tensec, sp_onesec, count, full, empty, ovf
    );

    modport slave (
        input  sel, tenmin, onemin, tensec, onesec, lap_req, clr, rd_idx,
        output lap_ack, rd_tenmin, rd_onemin, rd_tensec, rd_onesec,
               sp_tenmin, sp_onemin, sp_tensec, sp_onesec, count, full, empty, ovf
    );

endinterface

// File: rtl/bcd_time_sub.sv
// Combinational mm:ss BCD subtractor (diff = a - b) with a per-digit borrow chain;
// the final borrow is dropped so the result wraps modulo 60:00.
module bcd_time_sub
    import lap_pkg::*;
(
    input  time_t a,
    input  time_t b,
    output time_t diff
);

    function automatic logic borrows(bcd_t x, bcd_t y, logic bin);
        return {1'b0, x} < ({1'b0, y} + {4'b0, bin});
    endfunction

    // 4-bit wrap arithmetic, then add the digit radix back when the digit borrowed.
    function automatic bcd_t digit_sub(bcd_t x, bcd_t y, logic bin, bcd_t max);
        bcd_t t;
        t = x - y - {3'b0, bin};
        if (borrows(x, y, bin))
            t = t + max + 4'd1;
        return t;
    endfunction

    logic b_onesec, b_tensec, b_onemin;

    always_comb begin
        b_onesec    = borrows(a.onesec, b.onesec, 1'b0);
        b_tensec    = borrows(a.tensec, b.tensec, b_onesec);
        b_onemin    = borrows(a.onemin, b.onemin, b_tensec);
        diff.onesec = digit_sub(a.onesec, b.onesec, 1'b0,     ONES_MAX);
        diff.tensec = digit_sub(a.tensec, b.tensec, b_onesec, TENS_MAX);
        diff.onemin = digit_sub(a.onemin, b.onemin, b_tensec, ONES_MAX);
        diff.tenmin = digit_sub(a.tenmin, b.tenmin, b_onemin, TENS_MAX);
    end

endmodule

// File: rtl/lap_recorder.sv
// Lap/split capture stage: snapshots live BCD time on a lap request into a DEPTH-entry
// buffer with indexed registered read-back. Split storage is built only with LAP_SPLIT_EN.
module lap_recorder
    import lap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic           clk1sec,
    input  logic           rst,
    lap_recorder_if.slave  bus
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    state_t         state, state_nxt;
    time_t          live, cap_q, rd_q;
    logic [IDX_W:0] count_q;
    logic           ovf_q;
    logic           full_w, rd_hit;
    logic           accept, do_write, set_ovf;
    time_t          mem_time [DEPTH];

    assign live   = {bus.tenmin, bus.onemin, bus.tensec, bus.onesec};
    assign full_w = (count_q == DEPTH_C);
    assign rd_hit = ({1'b0, bus.rd_idx} < count_q);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_write  = 1'b0;
        set_ovf   = 1'b0;
        if (bus.clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (bus.lap_req && bus.sel == SEL_STOPWATCH) begin
                    accept    = 1'b1;
                    state_nxt = CAPT;
                end
                CAPT: state_nxt = CALC;
                CALC: begin
                    if (full_w) set_ovf  = 1'b1;
                    else        do_write = 1'b1;
                    state_nxt = ACK;
                end
                ACK:  if (!bus.lap_req) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk1sec) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk1sec) begin
        if (rst || bus.clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_write) count_q <= count_q + CNT_ONE;
            if (set_ovf)  ovf_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk1sec) begin
        if (rst)         cap_q <= '0;
        else if (accept) cap_q <= live;
    end

    // NOTE: the lap buffer has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk1sec) begin
        if (do_write) mem_time[count_q[IDX_W-1:0]] <= cap_q;
    end

    always_ff @(posedge clk1sec) begin
        if (rst)         rd_q <= '0;
        else if (rd_hit) rd_q <= mem_time[bus.rd_idx];
        else             rd_q <= '0;
    end

`ifdef LAP_SPLIT_EN
    time_t            sub_a_q, sub_b_q, split, sp_q;
    time_t            mem_split [DEPTH];
    logic [IDX_W-1:0] prev_idx;

    assign prev_idx = count_q[IDX_W-1:0] - IDX_W'(1);

    // CAPT registers the subtractor operands; the difference is consumed in CALC.
    always_ff @(posedge clk1sec) begin
        if (rst) begin
            sub_a_q <= '0;
            sub_b_q <= '0;
        end else if (state == CAPT) begin
            sub_a_q <= cap_q;
            sub_b_q <= (count_q == '0) ? time_t'('0) : mem_time[prev_idx];
        end
    end

    bcd_time_sub u_sub (
        .a    (sub_a_q),
        .b    (sub_b_q),
        .diff (split)
    );

    always_ff @(posedge clk1sec) begin
        if (do_write) mem_split[count_q[IDX_W-1:0]] <= split;
    end

    always_ff @(posedge clk1sec) begin
        if (rst)         sp_q <= '0;
        else if (rd_hit) sp_q <= mem_split[bus.rd_idx];
        else             sp_q <= '0;
    end

    assign bus.sp_tenmin = sp_q.tenmin;
    assign bus.sp_onemin = sp_q.onemin;
    assign bus.sp_tensec = sp_q.tensec;
    assign bus.sp_onesec = sp_q.onesec;
`else
    assign bus.sp_tenmin = '0;
    assign bus.sp_onemin = '0;
    assign bus.sp_tensec = '0;
    assign bus.sp_onesec = '0;
`endif

    assign bus.lap_ack   = (state == ACK);
    assign bus.count     = count_q;
    assign bus.full      = full_w;
    assign bus.empty     = (count_q == '0);
    assign bus.ovf       = ovf_q;
    assign bus.rd_tenmin = rd_q.tenmin;
    assign bus.rd_onemin = rd_q.onemin;
    assign bus.rd_tensec = rd_q.tensec;
    assign bus.rd_onesec = rd_q.onesec;

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: stimulus queues expected ack status and read data,
// a negedge monitor pops and compares whenever the DUT presents an ack or read result.
module tb_lap_recorder;
    import lap_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    typedef struct packed {
        logic [IDX_W:0] count;
        logic           full;
        logic           empty;
        logic           ovf;
    } ack_t;

    typedef struct packed {
        time_t t;
        time_t sp;
    } rd_t;

    logic clk1sec = 1'b0;
    logic rst     = 1'b1;

    lap_recorder_if #(.IDX_W(IDX_W)) bus ();

    lap_recorder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk1sec (clk1sec),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk1sec = ~clk1sec;

    int   n_pass  = 0;
    int   n_total = 0;
    ack_t ack_q[$];
    rd_t  rd_q[$];
    ack_t ack_exp;
    rd_t  rd_exp;
    logic rd_strobe   = 1'b0;
    logic rd_strobe_d = 1'b0;
    logic ack_prev    = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic time_t tm(int m10, int m1, int s10, int s1);
        return {4'(m10), 4'(m1), 4'(s10), 4'(s1)};
    endfunction

    function automatic time_t sp_exp(time_t s);
`ifdef LAP_SPLIT_EN
        return s;
`else
        return (s & '0);
`endif
    endfunction

    function automatic time_t rd_live();
        return {bus.rd_tenmin, bus.rd_onemin, bus.rd_tensec, bus.rd_onesec};
    endfunction

    function automatic time_t sp_live();
        return {bus.sp_tenmin, bus.sp_onemin, bus.sp_tensec, bus.sp_onesec};
    endfunction

    // Monitor: compare on each rising lap_ack and on each read result.
    always @(posedge clk1sec) rd_strobe_d <= rd_strobe;

    always @(negedge clk1sec) begin
        if (bus.lap_ack && !ack_prev) begin
            if (ack_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: ack with no pending request, count=%0d", bus.count);
            end else begin
                ack_exp = ack_q.pop_front();
                check("ack_status", 32'({bus.count, bus.full, bus.empty, bus.ovf}), 32'(ack_exp));
            end
        end
        ack_prev = bus.lap_ack;
        if (rd_strobe_d && rd_q.size() != 0) begin
            rd_exp = rd_q.pop_front();
            check("rd_time",  32'(rd_live()), 32'(rd_exp.t));
            check("rd_split", 32'(sp_live()), 32'(rd_exp.sp));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk1sec);
            #1;
        end
    endtask

    task automatic set_live(time_t t);
        bus.tenmin = t.tenmin;
        bus.onemin = t.onemin;
        bus.tensec = t.tensec;
        bus.onesec = t.onesec;
    endtask

    task automatic do_lap(time_t t, int exp_count, logic exp_ovf, int hold);
        ack_t a;
        int   cyc;
        a.count = (IDX_W+1)'(exp_count);
        a.full  = (exp_count == DEPTH);
        a.empty = (exp_count == 0);
        a.ovf   = exp_ovf;
        ack_q.push_back(a);
        set_live(t);
        bus.lap_req = 1'b1;
        cyc = 0;
        while (!bus.lap_ack && cyc < 10) begin
            tick();
            cyc++;
        end
        check("lap_latency", 32'(cyc), 32'd3);
        tick(hold);
        bus.lap_req = 1'b0;
        cyc = 0;
        while (bus.lap_ack && cyc < 10) begin
            tick();
            cyc++;
        end
        check("ack_release", 32'(bus.lap_ack), 32'd0);
    endtask

    task automatic do_read(int idx, time_t t, time_t sp);
        rd_t r;
        r.t  = t;
        r.sp = sp_exp(sp);
        rd_q.push_back(r);
        bus.rd_idx = IDX_W'(idx);
        rd_strobe  = 1'b1;
        tick();
        rd_strobe  = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks;
        bus.sel     = 2'b01;
        bus.lap_req = 1'b0;
        bus.clr     = 1'b0;
        bus.rd_idx  = '0;
        set_live(tm(0, 0, 0, 0));

        rst = 1'b1;
        tick(2);
        check("rst_ack",   32'(bus.lap_ack), 32'd0);
        check("rst_count", 32'(bus.count),   32'd0);
        check("rst_empty", 32'(bus.empty),   32'd1);
        check("rst_full",  32'(bus.full),    32'd0);
        check("rst_ovf",   32'(bus.ovf),     32'd0);
        check("rst_rd",    32'(rd_live()),   32'd0);
        check("rst_sp",    32'(sp_live()),   32'd0);
        rst = 1'b0;
        tick();

        // First and second lap, plus out-of-range read.
        do_lap(tm(0, 0, 0, 7), 1, 1'b0, 0);
        do_read(0, tm(0, 0, 0, 7), tm(0, 0, 0, 7));
        do_lap(tm(0, 1, 0, 2), 2, 1'b0, 0);
        do_read(1, tm(0, 1, 0, 2), tm(0, 0, 5, 5));
        do_read(2, tm(0, 0, 0, 0), tm(0, 0, 0, 0));

        // Split wraps through 59:59.
        do_clr();
        check("clr_count", 32'(bus.count), 32'd0);
        do_lap(tm(5, 9, 5, 0), 1, 1'b0, 0);
        do_lap(tm(0, 0, 1, 0), 2, 1'b0, 0);
        do_read(0, tm(5, 9, 5, 0), tm(5, 9, 5, 0));
        do_read(1, tm(0, 0, 1, 0), tm(0, 0, 2, 0));

        // Fill the buffer, then overflow.
        do_clr();
        for (int i = 1; i <= DEPTH; i++) do_lap(tm(0, 0, 0, i), i, 1'b0, 0);
        do_lap(tm(0, 0, 0, 9), DEPTH, 1'b1, 0);
        check("ovf_full", 32'(bus.full), 32'd1);
        do_read(7, tm(0, 0, 0, 8), tm(0, 0, 0, 1));
        do_read(0, tm(0, 0, 0, 1), tm(0, 0, 0, 1));
        do_clr();
        check("clr2_count", 32'(bus.count), 32'd0);
        check("clr2_empty", 32'(bus.empty), 32'd1);
        check("clr2_ovf",   32'(bus.ovf),   32'd0);
        check("clr2_full",  32'(bus.full),  32'd0);

        // Long-held request records one entry.
        do_lap(tm(0, 2, 3, 0), 1, 1'b0, 5);
        tick(3);
        check("hold_count", 32'(bus.count), 32'd1);
        do_read(0, tm(0, 2, 3, 0), tm(0, 2, 3, 0));

        // Requests ignored outside stopwatch mode.
        bus.sel     = 2'b00;
        bus.lap_req = 1'b1;
        acks = 0;
        repeat (6) begin
            tick();
            if (bus.lap_ack) acks++;
        end
        bus.lap_req = 1'b0;
        bus.sel     = 2'b01;
        tick();
        check("sel_acks",  32'(acks),      32'd0);
        check("sel_count", 32'(bus.count), 32'd1);

        // clr wins over a simultaneous lap request.
        bus.clr     = 1'b1;
        bus.lap_req = 1'b1;
        tick();
        bus.clr     = 1'b0;
        bus.lap_req = 1'b0;
        check("clrreq_count", 32'(bus.count), 32'd0);
        acks = 0;
        repeat (4) begin
            tick();
            if (bus.lap_ack) acks++;
        end
        check("clrreq_acks",  32'(acks),      32'd0);
        check("clrreq_count2", 32'(bus.count), 32'd0);

        // rst during CALC aborts the pending lap.
        do_lap(tm(0, 0, 0, 5), 1, 1'b0, 0);
        bus.rd_idx = '0;
        set_live(tm(0, 0, 0, 6));
        bus.lap_req = 1'b1;
        tick(2);
        rst         = 1'b1;
        bus.lap_req = 1'b0;
        tick();
        check("rstcalc_ack",   32'(bus.lap_ack), 32'd0);
        check("rstcalc_count", 32'(bus.count),   32'd0);
        check("rstcalc_empty", 32'(bus.empty),   32'd1);
        check("rstcalc_rd",    32'(rd_live()),   32'd0);
        rst = 1'b0;
        acks = 0;
        repeat (4) begin
            tick();
            if (bus.lap_ack) acks++;
        end
        check("rstcalc_acks",   32'(acks),      32'd0);
        check("rstcalc_count2", 32'(bus.count), 32'd0);

        tick(2);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("rd_queue_drained",  32'(rd_q.size()),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
